// File: rtl/fetch_ctrl_if.sv
// Bus bundle for fetch_ctrl: the instruction-memory request/grant/response
// port and the valid/ready port toward the ID stage.
interface fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_bus;

  // Fetch-controller side.
  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output out_valid, out_bus,
    input  out_ready
  );

  // Memory / ID side.
  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  out_valid, out_bus,
    output out_ready
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller. It owns the fetch PC, keeps at most one
// memory request outstanding, and tags each returned word with its address
// before queueing it for ID. A redirect restarts fetch and squashes all
// stale work, including a response still in flight.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h1C00_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  fetch_ctrl_if.master  bus
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t             r_state;
  logic [31:0]        r_fetch_pc;
  logic [31:0]        r_inflight_pc;
  logic               r_discard;
  logic [63:0]        r_buf [BUF_DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_pop;
  logic               w_rsp;
  logic               w_push;
  logic [CNT_W-1:0]   w_count_next;
  logic               w_credit;
  logic [31:0]        w_redirect_pc;
  logic               w_unused_pc_lsbs;

  assign w_pop         = bus.out_valid & bus.out_ready;
  assign w_rsp         = (r_state == S_WAIT) & bus.imem_rvalid;
  assign w_push        = w_rsp & ~r_discard;
  assign w_count_next  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  // After this cycle's push/pop nothing is in flight in IDLE or leaving WAIT,
  // so the post-update count alone decides whether a new request fits.
  assign w_credit      = (w_count_next < CNT_W'(BUF_DEPTH));
  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
  assign w_unused_pc_lsbs = ^redirect_pc[1:0];

  assign bus.imem_req  = (r_state == S_REQ);
  assign bus.imem_addr = r_fetch_pc;
  assign bus.out_valid = (r_count != '0);
  assign bus.out_bus   = r_buf[r_rd_ptr];

  // Fetch FSM: PC sequencing, in-flight tracking and stale-response discard.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_fetch_pc    <= RESET_PC;
      r_inflight_pc <= RESET_PC;
      r_discard     <= 1'b0;
    end else if (redirect) begin
      r_fetch_pc <= w_redirect_pc;
      case (r_state)
        S_REQ: begin
          if (bus.imem_gnt) begin
            // The old request was accepted anyway; wait out its response.
            r_inflight_pc <= r_fetch_pc;
            r_state       <= S_WAIT;
            r_discard     <= 1'b1;
          end else begin
            r_state <= S_REQ;
          end
        end
        S_WAIT: begin
          if (bus.imem_rvalid) begin
            r_state   <= S_REQ;
            r_discard <= 1'b0;
          end else begin
            r_discard <= 1'b1;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_credit) r_state <= S_REQ;
        end
        S_REQ: begin
          if (bus.imem_gnt) begin
            r_inflight_pc <= r_fetch_pc;
            r_fetch_pc    <= r_fetch_pc + 32'd4;
            r_state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.imem_rvalid) begin
            r_discard <= 1'b0;
            r_state   <= w_credit ? S_REQ : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Instruction buffer: circular FIFO of {pc, inst}, flushed on redirect.
  // NOTE: the storage is reset only because the head must read as zero out
  // of reset; a redirect just rewinds the pointers and leaves data in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) r_buf[i] <= '0;
    end else if (redirect) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_buf[r_wr_ptr] <= {r_inflight_pc, bus.imem_rdata};
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: a memory responder model, a cycle-indexed directed
// stimulus with hand-computed expectations, and a scoreboard monitor that
// checks every instruction ID consumes.
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;

  fetch_ctrl_if bus_if ();

  fetch_ctrl #(.RESET_PC(32'h1C00_0000), .BUF_DEPTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus_if)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];

  // Responder controls and bookkeeping.
  logic        gnt_en   = 1'b0;
  int          resp_lat = 1;
  int          gcount   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory model: grants while gnt_en, answers resp_lat cycles after grant
  // with rdata = address ^ FFFFFFFF. A pending answer survives DUT reset.
  initial begin : responder
    logic        fired;
    logic [31:0] faddr;
    logic        pend;
    logic [31:0] pend_data;
    int          pend_wait;
    pend = 1'b0;
    pend_data = '0;
    pend_wait = 0;
    bus_if.imem_gnt    = 1'b0;
    bus_if.imem_rvalid = 1'b0;
    bus_if.imem_rdata  = '0;
    forever begin
      @(negedge clk);
      fired = bus_if.imem_req && bus_if.imem_gnt;
      faddr = bus_if.imem_addr;
      @(posedge clk);
      #2;
      bus_if.imem_rvalid = 1'b0;
      if (fired) begin
        pend      = 1'b1;
        pend_data = faddr ^ 32'hFFFF_FFFF;
        pend_wait = resp_lat - 1;
        gcount++;
      end
      if (pend) begin
        if (pend_wait == 0) begin
          bus_if.imem_rvalid = 1'b1;
          bus_if.imem_rdata  = pend_data;
          pend = 1'b0;
        end else begin
          pend_wait--;
        end
      end
      bus_if.imem_gnt = gnt_en;
    end
  end

  // Scoreboard monitor: every consumed head must match the next expectation.
  always @(negedge clk) begin
    if (!reset && bus_if.out_valid && bus_if.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected actual=%h required=<no entry>", bus_if.out_bus);
      end else begin
        check("sb_out_bus", bus_if.out_bus, exp_q.pop_front());
      end
    end
  end

  initial begin : stimulus
    reset            = 1'b1;
    redirect         = 1'b0;
    redirect_pc      = '0;
    bus_if.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_imem_req",  64'(bus_if.imem_req),  64'd0);
    check("rst_imem_addr", 64'(bus_if.imem_addr), 64'h1C00_0000);
    check("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
    check("rst_out_bus",   bus_if.out_bus,        64'd0);
    @(posedge clk);
    #1;

    for (int c = 0; c <= 42; c++) begin
      // Drive at the start of cycle c.
      case (c)
        0: begin
          reset = 1'b0; gnt_en = 1'b1; resp_lat = 1; bus_if.out_ready = 1'b1;
          exp_q.push_back({32'h1C00_0000, 32'hE3FF_FFFF});
          exp_q.push_back({32'h1C00_0004, 32'hE3FF_FFFB});
          exp_q.push_back({32'h1C00_0008, 32'hE3FF_FFF7});
        end
        7:  gnt_en = 1'b0;
        8: begin
          gnt_en = 1'b1; bus_if.out_ready = 1'b0; gcount = 0;
          exp_q.push_back({32'h1C00_000C, 32'hE3FF_FFF3});
          exp_q.push_back({32'h1C00_0010, 32'hE3FF_FFEF});
        end
        16: bus_if.out_ready = 1'b1;
        17: resp_lat = 3;
        18: begin redirect = 1'b1; redirect_pc = 32'h1C00_0103; end
        19: begin redirect = 1'b0; resp_lat = 1; end
        23: begin redirect = 1'b1; redirect_pc = 32'h1C00_0201; bus_if.out_ready = 1'b0; end
        24: redirect = 1'b0;
        25: exp_q.push_back({32'h1C00_0200, 32'hE3FF_FDFF});
        30: begin redirect = 1'b1; redirect_pc = 32'h1C00_0302; bus_if.out_ready = 1'b1; end
        31: begin
          redirect = 1'b0;
          exp_q.push_back({32'h1C00_0300, 32'hE3FF_FCFF});
        end
        33: resp_lat = 3;
        34: reset = 1'b1;
        35: resp_lat = 1;
        36: reset = 1'b0;
        37: exp_q.push_back({32'h1C00_0000, 32'hE3FF_FFFF});
        39: gnt_en = 1'b0;
        default: ;
      endcase

      @(negedge clk);
      // Sample mid-cycle.
      if (c <= 7)
        check($sformatf("seq_out_valid_c%0d", c), 64'(bus_if.out_valid),
              64'((c == 3) || (c == 5) || (c == 7)));
      case (c)
        0: check("start_idle_req", 64'(bus_if.imem_req), 64'd0);
        1: begin
          check("start_req",  64'(bus_if.imem_req),  64'd1);
          check("start_addr", 64'(bus_if.imem_addr), 64'h1C00_0000);
        end
        7: begin
          check("hold_req",  64'(bus_if.imem_req),  64'd1);
          check("hold_addr", 64'(bus_if.imem_addr), 64'h1C00_000C);
        end
        12, 13, 14, 15: begin
          check($sformatf("full_no_req_c%0d", c), 64'(bus_if.imem_req),  64'd0);
          check($sformatf("full_valid_c%0d", c),  64'(bus_if.out_valid), 64'd1);
          if (c == 15) check("full_grants", 64'(gcount), 64'd2);
        end
        16: check("pop_cycle_req", 64'(bus_if.imem_req), 64'd0);
        17: begin
          check("credit_req",  64'(bus_if.imem_req),  64'd1);
          check("credit_addr", 64'(bus_if.imem_addr), 64'h1C00_0014);
        end
        19: check("wait_redir_valid", 64'(bus_if.out_valid), 64'd0);
        20: check("wait_redir_req",   64'(bus_if.imem_req),  64'd0);
        21: begin
          check("wait_redir_req2", 64'(bus_if.imem_req),  64'd1);
          check("wait_redir_addr", 64'(bus_if.imem_addr), 64'h1C00_0100);
        end
        23: begin
          check("redir_head_valid", 64'(bus_if.out_valid), 64'd1);
          check("redir_head_bus",   bus_if.out_bus, {32'h1C00_0100, 32'hE3FF_FEFF});
        end
        24: check("gnt_redir_flush", 64'(bus_if.out_valid), 64'd0);
        25: begin
          check("gnt_redir_req",  64'(bus_if.imem_req),  64'd1);
          check("gnt_redir_addr", 64'(bus_if.imem_addr), 64'h1C00_0200);
        end
        29: check("full2_idle_req", 64'(bus_if.imem_req), 64'd0);
        30: check("full2_valid", 64'(bus_if.out_valid), 64'd1);
        31: begin
          check("fire_redir_valid", 64'(bus_if.out_valid), 64'd0);
          check("fire_redir_req",   64'(bus_if.imem_req),  64'd1);
          check("fire_redir_addr",  64'(bus_if.imem_addr), 64'h1C00_0300);
        end
        35: begin
          check("midrst_req",   64'(bus_if.imem_req),  64'd0);
          check("midrst_addr",  64'(bus_if.imem_addr), 64'h1C00_0000);
          check("midrst_valid", 64'(bus_if.out_valid), 64'd0);
        end
        36: begin
          check("stale_rsp_req",   64'(bus_if.imem_req),  64'd0);
          check("stale_rsp_valid", 64'(bus_if.out_valid), 64'd0);
        end
        37: begin
          check("restart_req",  64'(bus_if.imem_req),  64'd1);
          check("restart_addr", 64'(bus_if.imem_addr), 64'h1C00_0000);
        end
        42: check("sb_drained", 64'(exp_q.size()), 64'd0);
        default: ;
      endcase
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller between the instruction-memory port and the ID stage. It owns the fetch PC, issues one instruction-memory request at a time over a request/grant/response bus, and tags each returned word with its address. Results go into a small FIFO that ID drains with valid/ready. Branch redirects from EXE restart fetch at a new PC and discard every stale instruction, including any response still in flight.

## Interface
- RESET_PC, 32'h1C000000, fetch address after reset
- BUF_DEPTH, 2, instruction-buffer entries (power of two, ≥2)

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- redirect  in  1  branch/flush taken this cycle
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (forced 0)
- imem_req  out  1  request valid
- imem_addr  out  32  request address, word-aligned
- imem_gnt  in  1  request accepted this cycle (only meaningful with imem_req)
- imem_rvalid  in  1  response valid, at least 1 cycle after grant
- imem_rdata  in  32  response instruction word
- out_valid  out  1  buffer head valid to ID
- out_ready  in  1  ID allows in
- out_bus  out  64  {pc[63:32], inst[31:0]} of buffer head

## Operation
- Registers:
  - fetch PC
  - in-flight PC
  - discard flag
  - FIFO of BUF_DEPTH × 64 bits, with its count
  - state: IDLE / REQ / WAIT
- Outputs:
  - imem_req = (state==REQ).
  - imem_addr = fetch PC.
  - out_valid = (count≠0).
  - out_bus = FIFO head.
- Credit: issue is allowed only when count + (state==WAIT) < BUF_DEPTH. Counting the in-flight request means the FIFO never overflows.
- IDLE:
  - → REQ when credit is available.
  - Otherwise stay.
- REQ:
  - On imem_gnt: in-flight PC ← fetch PC; fetch PC ← fetch PC+4 (mod 2^32); → WAIT.
  - Without grant: hold state and address.
- WAIT, on imem_rvalid:
  - If discard=0, push {in-flight PC, imem_rdata}.
  - Clear discard.
  - Next state: REQ if credit is available after this cycle's push/pop, else IDLE.
- FIFO: pop when out_valid & out_ready. Push and pop in the same cycle are allowed, including when full, since pop makes room.
- Redirect (highest priority, any state):
  - fetch PC ← {redirect_pc[31:2],2'b00}.
  - FIFO count ← 0. A simultaneous out fire counts as consumed; no other effect.
  - State and discard by case:
    - IDLE or REQ without gnt: → REQ.
    - REQ with gnt the same cycle: the old request is in flight → WAIT, discard=1.
    - WAIT without rvalid: stay WAIT, discard=1.
    - WAIT with rvalid: response dropped → REQ, discard=0.
- The address may change while imem_req is high only on redirect. The bus treats an ungranted request as withdrawn.

## Timing
- Reset values:
  - state IDLE, fetch PC = RESET_PC, discard 0, count 0.
  - imem_req 0, imem_addr RESET_PC.
  - out_valid 0, out_bus 0.
- Reset mid-operation: everything returns to reset values next edge. Any outstanding response arriving after reset is deasserted must be ignored; reset sets discard=0 and state IDLE, so an rvalid in IDLE/REQ is dropped.
- Startup: reset low at cycle 0 → IDLE; cycle 1 REQ, imem_req=1, imem_addr=RESET_PC.
- Minimum fetch latency:
  - grant cycle n (REQ), rvalid earliest cycle n+1 (WAIT).
  - FIFO push at end of n+1; out_valid=1 in cycle n+2.
- Peak throughput: one instruction per 2 cycles (REQ/WAIT alternation).
- Full buffer: no request is issued until a pop frees credit. State returns IDLE→REQ the cycle after the pop.
- rvalid outside WAIT is ignored.

## Test plan
- Reset, then gnt whenever requested, rvalid 1 cycle after gnt with rdata = address ^ 32'hFFFF_FFFF, out_ready=1 → out_bus = {1C000000, E3FFFFFF}, {1C000004, E3FFFFFB}, … with out_valid on cycles 3, 5, 7.
- out_ready=0 with BUF_DEPTH=2 → exactly 2 grants, then imem_req stays 0. Raise out_ready → head pops, and imem_req reasserts the next cycle.
- Redirect to 32'h1C000103 while in WAIT, rvalid arriving 2 cycles later → that response is not pushed. The next imem_addr is 1C000100, and the first out_bus pc is 1C000100.
- Redirect in the same cycle as imem_gnt in REQ → the old response is discarded, a new request for the redirect address follows it, and the FIFO count is 0 after the redirect.
- Redirect with a full FIFO and out fire in the same cycle → out_valid=0 the next cycle, and no stale entry appears later.
- Assert reset while in WAIT, then pulse rvalid → no push; fetch restarts at 1C000000.
